// File: rtl/vga_timing_controller.sv
// vga_timing_controller
//
// Generates VGA raster timing from a single-cycle pixel strobe. A horizontal
// counter (h_cnt) and a vertical counter (v_cnt) sweep the whole raster,
// including the blanking intervals. Each axis also has a phase FSM
// (ACTIVE/FRONT/SYNC/BACK) that moves in step with its counter.
//
// Every output is registered. On a strobe, the outputs take the decode of
// the current counts, and then the counts advance. So the outputs trail the
// counters by one pix_en tick.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   run control; low clears everything synchronously and holds
//   pix_en      in   pixel strobe; all timing advances only when it is high
//   hsync       out  horizontal sync, active level SYNC_POL
//   vsync       out  vertical sync, active level SYNC_POL
//   video_on    out  output pixel lies in the visible area
//   pixel_x     out  horizontal position of the current outputs
//   pixel_y     out  line number of the current outputs
//   line_start  out  one-clk pulse on the tick that outputs pixel_x = 0
//   frame_start out  one-clk pulse on the tick that outputs (0,0)
//   h_state     out  horizontal phase: 0 ACTIVE, 1 FRONT, 2 SYNC, 3 BACK
//
// Each porch, sync and active interval is assumed to be at least one count long.
module vga_timing_controller #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic [1:0]       h_state
);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last count of each phase. The FSM leaves a phase when its counter
    // sits on that phase's last count and a step is taken.
    localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_FP_LAST   = CNT_W'(H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] H_SYNC_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_FP_LAST   = CNT_W'(V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] V_SYNC_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);

    // Counters, and the phase that belongs to the current count.
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    phase_t           h_ph_q, h_ph_d;
    phase_t           v_ph_q, v_ph_d;

    // Registered outputs.
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
    logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [1:0]       h_state_q, h_state_d;

    logic h_wrap;
    logic v_wrap;

    // Phase that follows a step taken from count 'cnt' while in phase 'ph'.
    function automatic phase_t next_phase(
        input phase_t           ph,
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] act_last,
        input logic [CNT_W-1:0] fp_last,
        input logic [CNT_W-1:0] sync_last,
        input logic [CNT_W-1:0] last
    );
        phase_t nxt;
        nxt = ph;
        case (ph)
            PH_ACTIVE: if (cnt == act_last)  nxt = PH_FRONT;
            PH_FRONT:  if (cnt == fp_last)   nxt = PH_SYNC;
            PH_SYNC:   if (cnt == sync_last) nxt = PH_BACK;
            PH_BACK:   if (cnt == last)      nxt = PH_ACTIVE;
            default:                         nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_ph_d        = h_ph_q;
        v_ph_d        = v_ph_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        h_state_d     = h_state_q;
        // The pulses last only one clk. They fall on every clk that does
        // not load a new line start.
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (!enable) begin
            // Clear takes priority over a coincident strobe, and it drops
            // the frame in progress at once.
            h_cnt_d    = '0;
            v_cnt_d    = '0;
            h_ph_d     = PH_ACTIVE;
            v_ph_d     = PH_ACTIVE;
            hsync_d    = ~SYNC_POL;
            vsync_d    = ~SYNC_POL;
            video_on_d = 1'b0;
            pixel_x_d  = '0;
            pixel_y_d  = '0;
            h_state_d  = PH_ACTIVE;
        end else if (pix_en) begin
            // Outputs take the decode of the counts as they stand now.
            hsync_d       = (h_ph_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = (v_ph_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on_d    = (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
            pixel_x_d     = h_cnt_q;
            pixel_y_d     = v_cnt_q;
            h_state_d     = h_ph_q;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

            // Then the raster position advances.
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            h_ph_d  = next_phase(h_ph_q, h_cnt_q, H_ACT_LAST, H_FP_LAST,
                                 H_SYNC_LAST, H_LAST);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
                v_ph_d  = next_phase(v_ph_q, v_cnt_q, V_ACT_LAST, V_FP_LAST,
                                     V_SYNC_LAST, V_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_ph_q        <= PH_ACTIVE;
            v_ph_q        <= PH_ACTIVE;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_state_q     <= PH_ACTIVE;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_ph_q        <= h_ph_d;
            v_ph_q        <= v_ph_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            h_state_q     <= h_state_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_state     = h_state_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller
//
// Directed bench for vga_timing_controller. u_dflt uses the default 640x480
// timing. u_small uses a tiny raster (H 4/1/2/1, V 3/1/1/1, active-high syncs,
// 3-bit counters) so that a whole frame and its wrap fit in a short run.
module tb_vga_timing_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance
    logic       rst_n0, en0, pe0;
    logic       hs0, vs0, von0, ls0, fs0;
    logic [9:0] px0, py0;
    logic [1:0] hst0;

    // Small-timing instance
    logic       rst_n1, en1, pe1;
    logic       hs1, vs1, von1, ls1, fs1;
    logic [2:0] px1, py1;
    logic [1:0] hst1;

    vga_timing_controller u_dflt (
        .clk        (clk),
        .rst_n      (rst_n0),
        .enable     (en0),
        .pix_en     (pe0),
        .hsync      (hs0),
        .vsync      (vs0),
        .video_on   (von0),
        .pixel_x    (px0),
        .pixel_y    (py0),
        .line_start (ls0),
        .frame_start(fs0),
        .h_state    (hst0)
    );

    vga_timing_controller #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CNT_W(3)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n1),
        .enable     (en1),
        .pix_en     (pe1),
        .hsync      (hs1),
        .vsync      (vs1),
        .video_on   (von1),
        .pixel_x    (px1),
        .pixel_y    (py1),
        .line_start (ls1),
        .frame_start(fs1),
        .h_state    (hst1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Move one clk forward and settle 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int hs_lo, hs_min, hs_max, ls_extra;
    int ticks, exp_x, exp_y, bad, ls_n, ls_wide, fs_n;
    int ls_at [2];
    int hst_exp [8] = '{0, 0, 0, 0, 1, 2, 2, 3};

    initial begin
        rst_n0 = 1'b0; en0 = 1'b0; pe0 = 1'b0;
        rst_n1 = 1'b0; en1 = 1'b0; pe1 = 1'b0;
        repeat (3) step();

        // ---- reset state ----
        check("rst_px", 32'(px0), 0);
        check("rst_py", 32'(py0), 0);
        check("rst_von", 32'(von0), 0);
        check("rst_hsync", 32'(hs0), 1);
        check("rst_vsync", 32'(vs0), 1);
        check("rst_ls", 32'(ls0), 0);
        check("rst_fs", 32'(fs0), 0);
        check("rst_hstate", 32'(hst0), 0);
        check("rst_small_hsync", 32'(hs1), 0);
        check("rst_small_vsync", 32'(vs1), 0);
        $display("reset checked");

        // ---- first tick after release ----
        rst_n0 = 1'b1; rst_n1 = 1'b1; en0 = 1'b1; pe0 = 1'b1;
        step();
        check("t1_px", 32'(px0), 0);
        check("t1_py", 32'(py0), 0);
        check("t1_von", 32'(von0), 1);
        check("t1_fs", 32'(fs0), 1);
        check("t1_ls", 32'(ls0), 1);
        $display("tick 1: px=%0d py=%0d von=%0d fs=%0d ls=%0d", px0, py0, von0, fs0, ls0);

        // ---- rest of line 0 ----
        hs_lo = 0; hs_min = 9999; hs_max = -1; ls_extra = 0;
        for (int k = 2; k <= 800; k++) begin
            step();
            if (hs0 == 1'b0) begin
                hs_lo++;
                if (int'(px0) < hs_min) hs_min = int'(px0);
                if (int'(px0) > hs_max) hs_max = int'(px0);
            end
            if (ls0) ls_extra++;
            if (k == 2) check("ls_one_clk", 32'(ls0), 0);
            if (k == 641) begin
                check("t641_px", 32'(px0), 640);
                check("t641_von", 32'(von0), 0);
                check("t641_hstate", 32'(hst0), 1);
            end
        end
        check("hsync_ticks", hs_lo, 96);
        check("hsync_first_x", hs_min, 656);
        check("hsync_last_x", hs_max, 751);
        check("ls_in_line", ls_extra, 0);
        $display("line 0: hsync low %0d ticks, x %0d..%0d", hs_lo, hs_min, hs_max);

        // Tick 801 starts line 1, so line_start repeats after 800 ticks.
        step();
        check("t801_px", 32'(px0), 0);
        check("t801_py", 32'(py0), 1);
        check("t801_ls", 32'(ls0), 1);
        check("t801_fs", 32'(fs0), 0);
        $display("tick 801: px=%0d py=%0d ls=%0d fs=%0d", px0, py0, ls0, fs0);

        // ---- enable drop mid-line at (300,1), with pix_en still high ----
        repeat (300) step();
        check("mid_px", 32'(px0), 300);
        check("mid_py", 32'(py0), 1);
        en0 = 1'b0;
        step();
        check("clr_px", 32'(px0), 0);
        check("clr_py", 32'(py0), 0);
        check("clr_von", 32'(von0), 0);
        check("clr_hsync", 32'(hs0), 1);
        check("clr_ls", 32'(ls0), 0);
        step(); step();
        check("clr_hold_px", 32'(px0), 0);
        check("clr_hold_von", 32'(von0), 0);
        en0 = 1'b1;
        step();
        check("reen_px", 32'(px0), 0);
        check("reen_py", 32'(py0), 0);
        check("reen_von", 32'(von0), 1);
        check("reen_fs", 32'(fs0), 1);
        check("reen_ls", 32'(ls0), 1);
        $display("enable clear/restart: px=%0d py=%0d fs=%0d", px0, py0, fs0);

        // ---- asynchronous reset between edges, during hsync ----
        repeat (700) step();
        check("pre_arst_px", 32'(px0), 700);
        check("pre_arst_hsync", 32'(hs0), 0);
        check("pre_arst_hstate", 32'(hst0), 2);
        #3 rst_n0 = 1'b0;
        #1;
        check("arst_px", 32'(px0), 0);
        check("arst_hsync", 32'(hs0), 1);
        check("arst_hstate", 32'(hst0), 0);
        check("arst_von", 32'(von0), 0);
        step();
        rst_n0 = 1'b1;
        step();
        check("arst_rel_px", 32'(px0), 0);
        check("arst_rel_fs", 32'(fs0), 1);
        check("arst_rel_von", 32'(von0), 1);
        $display("async reset: px=%0d fs=%0d", px0, fs0);

        // ---- pix_en every second clk ----
        en0 = 1'b0;
        step();
        en0 = 1'b1;
        ticks = 0; bad = 0; ls_n = 0; ls_wide = 0;
        ls_at[0] = -1; ls_at[1] = -1;
        for (int c = 0; c < 1700; c++) begin
            pe0 = ((c % 2) == 0);
            step();
            if (pe0) ticks++;
            exp_x = (ticks - 1) % 800;
            exp_y = (ticks - 1) / 800;
            if (int'(px0) != exp_x || int'(py0) != exp_y || von0 !== (exp_x < 640)) bad++;
            if (ls0) begin
                if (c % 2) ls_wide++;
                if (ls_n < 2) ls_at[ls_n] = c;
                ls_n++;
            end
        end
        check("div2_pixels", bad, 0);
        check("div2_ls_count", ls_n, 2);
        check("div2_ls_first", ls_at[0], 0);
        check("div2_ls_period", ls_at[1] - ls_at[0], 1600);
        check("div2_ls_on_idle", ls_wide, 0);
        $display("div2: ls at clk %0d and %0d", ls_at[0], ls_at[1]);

        // ---- small raster: full frame and wrap ----
        en1 = 1'b1; pe1 = 1'b1;
        bad = 0; fs_n = 0;
        for (int k = 1; k <= 49; k++) begin
            step();
            exp_x = (k - 1) % 8;
            exp_y = ((k - 1) / 8) % 6;
            if (int'(px1) != exp_x || int'(py1) != exp_y) bad++;
            if (hs1 !== (exp_x == 5 || exp_x == 6)) bad++;
            if (vs1 !== (exp_y == 4)) bad++;
            if (int'(hst1) != hst_exp[exp_x]) bad++;
            if (von1 !== (exp_x < 4 && exp_y < 3)) bad++;
            if (ls1 !== (exp_x == 0)) bad++;
            if (fs1) fs_n++;
            if (k == 48) begin
                check("small_last_px", 32'(px1), 7);
                check("small_last_py", 32'(py1), 5);
            end
            if (k == 49) begin
                check("small_wrap_px", 32'(px1), 0);
                check("small_wrap_py", 32'(py1), 0);
                check("small_wrap_fs", 32'(fs1), 1);
            end
        end
        check("small_frame_decode", bad, 0);
        check("small_fs_count", fs_n, 2);
        $display("small frame: %0d frame_start pulses in 49 ticks", fs_n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Sequences VGA raster timing from the single-cycle pixel strobe produced by the team's clock-divider block.
- Counts pixels and lines, runs horizontal and vertical phase FSMs (ACTIVE/FRONT/SYNC/BACK), and drives hsync/vsync, video_on and pixel coordinates.
- Sits between the pixel-clock divider and the pixel-generation logic.
- Default timing is 640x480@60.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- CNT_W, 10, counter/coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W

Ports:
- clk  in  1  system clock (one clock domain)
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run control; low = synchronous clear and hold
- pix_en  in  1  single-clk pixel strobe from the divider; all timing advances only on cycles with pix_en=1
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- video_on  out  1  high while the output pixel is in the visible area
- pixel_x  out  CNT_W  horizontal count for the current outputs
- pixel_y  out  CNT_W  line count for the current outputs
- line_start  out  1  one-clk pulse when pixel_x becomes 0
- frame_start  out  1  one-clk pulse when (pixel_x, pixel_y) becomes (0,0)
- h_state  out  2  horizontal FSM state: 0 ACTIVE, 1 FRONT, 2 SYNC, 3 BACK

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Internal counters: h_cnt ranges 0..H_TOTAL-1 and v_cnt ranges 0..V_TOTAL-1.
- Every output is registered. On a clk edge with enable=1 and pix_en=1:
  - Outputs load the decode of the current (h_cnt, v_cnt).
  - pixel_x loads h_cnt and pixel_y loads v_cnt.
  - The counters then advance.
- This gives one pix_en tick of latency from count to output.
- Advance rule:
  - h_cnt increments by 1.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 together with the h wrap, v_cnt wraps to 0.
- Horizontal FSM, decoded from h_cnt:
  - ACTIVE for h < H_ACTIVE
  - FRONT for H_ACTIVE ≤ h < H_ACTIVE+H_FP
  - SYNC for the next H_SYNC counts
  - BACK for the remaining counts, then returns to ACTIVE on wrap
- Vertical FSM: same four phases on v_cnt. It advances only on h wrap.
- hsync = SYNC_POL when the horizontal FSM is in SYNC, otherwise ~SYNC_POL. vsync follows the same rule on the vertical FSM.
- video_on = 1 only when both FSMs are in ACTIVE.
- line_start = 1 for exactly one clk on the tick that loads pixel_x = 0. frame_start additionally requires pixel_y = 0. Both are 0 on every other clk, including non-pix_en clocks.
- pix_en=0 clocks: all outputs hold their values, except line_start and frame_start, which drop to 0.
- Reset (rst_n=0, async) and enable=0 (synchronous) produce the same state:
  - h_cnt = v_cnt = 0, pixel_x = pixel_y = 0, h_state = ACTIVE
  - hsync = vsync = ~SYNC_POL (inactive)
  - video_on = line_start = frame_start = 0
- Reset or enable=0 mid-frame abandons the frame immediately; there is no completion of the current line.
- After release (rst_n or enable returning high), the first pix_en tick outputs (0,0) with video_on=1 and frame_start=line_start=1.
- enable=0 and pix_en=1 in the same clk: clear wins.
- pix_en asserted on consecutive clocks (divide-by-1) must work, with one count per clk.

Test Plan:
- Reset, then enable=1 with pix_en every clk (defaults) -> on the first tick pixel=(0,0), video_on=1, frame_start=1 and line_start=1 for one clk. On tick 641, pixel_x=640, video_on=0, h_state=FRONT.
- Defaults over one full line -> hsync=0 exactly while pixel_x=656..751 (96 ticks). line_start repeats every 800 ticks.
- Defaults over a full frame -> vsync=0 exactly while pixel_y=490..491 (1600 ticks). frame_start repeats every 420000 ticks. After pixel (799,524), the next tick is (0,0).
- pix_en every 2nd clk -> all outputs stable across non-strobe clocks; line_start/frame_start are only 1 clk wide; line period is 1600 clks.
- Mid-line at pixel (300,100): drop enable for 3 clks, then raise it -> outputs cleared the clk after enable falls, and the first tick after re-enable gives (0,0) with frame_start=1. Repeat using async rst_n asserted between clock edges -> outputs clear without waiting for a clock edge.
- Small config (H=4/1/2/1, V=3/1/1/1, SYNC_POL=1) -> hsync=1 at pixel_x=5..6, vsync=1 at pixel_y=4, frame of 48 ticks, h_state sequence 0,0,0,0,1,2,2,3.
